// File: rtl/mem_dump_reader.sv
// Walks a word range of instruction memory and streams each 32-bit word out
// LSB-first as four bytes on a valid/ready byte interface.
module mem_dump_reader #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  output logic [ADDR_W-1:0] Address,
  output logic              CS,
  output logic              OE,
  output logic              WE,
  input  logic [DATA_W-1:0] DataOut,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start; done pulses from here
  // READ  | memory selected, waiting READ_LATENCY edges for DataOut
  // SEND  | streaming the captured word, one byte per transfer
  typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_cs;
  logic              r_oe;
  logic [7:0]        r_byte_out;
  logic              r_byte_valid;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_remaining;
  logic [1:0]        r_wait;
  logic [1:0]        r_byte_idx;
  logic [31:0]       r_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_cs         <= 1'b1;
      r_oe         <= 1'b0;
      r_byte_out   <= '0;
      r_byte_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_remaining  <= '0;
      r_wait       <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (word_count == 16'd0) begin
              r_done <= 1'b1;
            end else begin
              r_addr      <= base_addr;
              r_remaining <= word_count;
              r_cs        <= 1'b0;
              r_oe        <= 1'b1;
              r_wait      <= LAT_LOAD;
              r_busy      <= 1'b1;
              r_state     <= READ;
            end
          end
        end
        READ: begin
          if (r_wait == 2'd0) begin
            r_word       <= DataOut[31:0];
            r_byte_out   <= DataOut[7:0];
            r_byte_idx   <= 2'd0;
            r_byte_valid <= 1'b1;
            r_cs         <= 1'b1;
            r_oe         <= 1'b0;
            r_state      <= SEND;
          end else begin
            r_wait <= r_wait - 2'd1;
          end
        end
        SEND: begin
          if (byte_ready) begin
            if (r_byte_idx == 2'd3) begin
              r_byte_valid <= 1'b0;
              if (r_remaining > 16'd1) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - 16'd1;
                r_cs        <= 1'b0;
                r_oe        <= 1'b1;
                r_wait      <= LAT_LOAD;
                r_state     <= READ;
              end else begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_word     <= r_word >> 8;
              r_byte_out <= r_word[15:8];
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Address    = r_addr;
  assign CS         = r_cs;
  assign OE         = r_oe;
  assign WE         = 1'b0;
  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader: byte order, stalls, zero count, address
// wrap, ignored start while busy and mid-dump reset.
module tb_mem_dump_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic [31:0] Address;
  logic        CS, OE, WE;
  logic [31:0] DataOut;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  bq[$];
  logic [31:0] aq[$];
  int          done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_byte = '0;

  mem_dump_reader #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .Address(Address), .CS(CS), .OE(OE), .WE(WE),
    .DataOut(DataOut), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'hAABBCCDD;
      32'h0000_0011: return 32'h11223344;
      32'hFFFF_FFFF: return 32'hCAFEF00D;
      32'h0000_0000: return 32'h0BADBEEF;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  always_comb DataOut = (!CS && OE) ? memf(Address) : 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe on the falling edge: a transfer seen here completes at the next rising edge.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", byte_valid, 1'b1);
        chk("stall_byte", byte_out, prev_byte);
      end
      if (byte_valid && byte_ready) bq.push_back(byte_out);
      if (!CS && OE) aq.push_back(Address);
      if (done) done_cnt++;
      prev_stall = byte_valid && !byte_ready;
      prev_byte  = byte_out;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input string tag, input bit toggle);
    int n;
    n = 0;
    while (!done && n < 300) begin
      tick();
      if (toggle) byte_ready = ~byte_ready;
      n++;
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr"}, Address, 32'h0);
    chk({tag, "_cs"}, CS, 1'b1);
    chk({tag, "_oe"}, OE, 1'b0);
    chk({tag, "_we"}, WE, 1'b0);
    chk({tag, "_byte"}, byte_out, 8'h00);
    chk({tag, "_valid"}, byte_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  logic [7:0] exp1 [8];
  int         d0;

  initial begin
    exp1 = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    tick();
    check_reset_vals("rst");
    #2 reset = 1'b0;
    tick();

    // 1: two words, sink always ready
    byte_ready = 1'b1;
    bq.delete(); aq.delete(); done_cnt = 0;
    do_start(32'h10, 16'd2);
    chk("t1_addr", Address, 32'h10);
    chk("t1_cs", CS, 1'b0);
    chk("t1_oe", OE, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_novalid", byte_valid, 1'b0);
    tick();
    chk("t1_first_valid", byte_valid, 1'b1);
    chk("t1_first_byte", byte_out, 8'hDD);
    chk("t1_cs_send", CS, 1'b1);
    wait_done("t1_done", 1'b0);
    chk("t1_busy_end", busy, 1'b0);
    tick();
    chk("t1_done_pulse", done, 1'b0);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_nbytes", bq.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_byte%0d", i), bq[i], exp1[i]);
    chk("t1_nreads", aq.size(), 2);
    chk("t1_rd1", aq[1], 32'h11);

    // 2: same dump with the sink toggling ready every cycle
    bq.delete(); aq.delete(); done_cnt = 0;
    byte_ready = 1'b0;
    do_start(32'h10, 16'd2);
    wait_done("t2_done", 1'b1);
    tick();
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_nbytes", bq.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_byte%0d", i), bq[i], exp1[i]);

    // 3: zero count
    byte_ready = 1'b1;
    bq.delete(); aq.delete(); done_cnt = 0;
    do_start(32'h10, 16'd0);
    chk("t3_done", done, 1'b1);
    chk("t3_cs", CS, 1'b1);
    chk("t3_oe", OE, 1'b0);
    chk("t3_busy", busy, 1'b0);
    tick();
    chk("t3_done_pulse", done, 1'b0);
    tick();
    chk("t3_nreads", aq.size(), 0);
    chk("t3_nbytes", bq.size(), 0);
    chk("t3_done_cnt", done_cnt, 1);

    // 4: address wrap
    bq.delete(); aq.delete(); done_cnt = 0;
    do_start(32'hFFFF_FFFF, 16'd2);
    wait_done("t4_done", 1'b0);
    tick();
    chk("t4_nreads", aq.size(), 2);
    chk("t4_rd0", aq[0], 32'hFFFF_FFFF);
    chk("t4_rd1", aq[1], 32'h0000_0000);
    chk("t4_nbytes", bq.size(), 8);
    chk("t4_byte0", bq[0], 8'h0D);
    chk("t4_byte4", bq[4], 8'hEF);
    chk("t4_byte7", bq[7], 8'h0B);

    // 5: start while busy is ignored
    bq.delete(); aq.delete(); done_cnt = 0;
    do_start(32'h20, 16'd3);
    tick();
    chk("t5_in_send", byte_valid, 1'b1);
    do_start(32'h40, 16'd5);
    wait_done("t5_done", 1'b0);
    tick(); tick(); tick();
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_nbytes", bq.size(), 12);
    chk("t5_nreads", aq.size(), 3);
    chk("t5_rd2", aq[2], 32'h22);
    chk("t5_byte0", bq[0], 8'hDF);
    chk("t5_byte4", bq[4], 8'hDE);
    chk("t5_byte11", bq[11], 8'h00);
    chk("t5_idle", busy, 1'b0);

    // 6: reset after the second byte, then a clean single-word dump
    bq.delete(); aq.delete(); done_cnt = 0;
    do_start(32'h10, 16'd2);
    tick(); tick(); tick();
    chk("t6_pre_nbytes", bq.size(), 2);
    chk("t6_pre_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_reset_vals("t6_rst");
    tick();
    #2 reset = 1'b0;
    tick(); tick();
    chk("t6_no_done", done_cnt, 0);
    d0 = bq.size();
    chk("t6_nbytes_after_rst", d0, 2);
    bq.delete(); aq.delete();
    do_start(32'h11, 16'd1);
    wait_done("t6_done", 1'b0);
    tick();
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_nbytes", bq.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t6_byte%0d", i), bq[i], exp1[4 + i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
